// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: data width, LSU state encoding,
// load/store funct3 codes and legality/alignment helpers.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int LSU_MAX_WAIT_DEFAULT = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [1:0] lane
  );
    logic mis;
    mis = 1'b0;
    unique case (1'b1)
      f3 == F3_H,
      f3 == F3_HU: mis = lane[0];
      f3 == F3_W:  mis = |lane;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b         = rdata[{lane, 3'b000} +: 8];
    h         = lane[1] ? rdata[31:16] : rdata[15:0];
    mem_be    = 4'b1111;
    mem_wdata = wdata;
    ld_data   = rdata;
    if (we) begin
      unique case (1'b1)
        funct3 == F3_B: begin
          mem_be    = 4'b0001 << lane;
          mem_wdata = {4{wdata[7:0]}};
        end
        funct3 == F3_H: begin
          mem_be    = lane[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end else begin
      unique case (1'b1)
        funct3 == F3_B:  ld_data = {{24{b[7]}}, b};
        funct3 == F3_BU: ld_data = {24'd0, b};
        funct3 == F3_H:  ld_data = {{16{h[15]}}, h};
        funct3 == F3_HU: ld_data = {16'd0, h};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding access, word-addressed
// memory port with byte enables and a bounded read wait.
module lsu
  import rv32i_pkg::*;
#(
  parameter int MAX_WAIT = LSU_MAX_WAIT_DEFAULT
) (
  input  logic            clk,
  input  logic            areset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_misaligned,
  output logic            rsp_err,
  output logic            busy,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_e      state;
  logic [CW-1:0]   cnt;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            mis_q;
  logic            err_q;
  logic [3:0]      be_w;
  logic [31:0]     ld_w;

  lsu_align u_align (
    .we        (we_q),
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .mem_be    (be_w),
    .mem_wdata (mem_wdata),
    .ld_data   (ld_w)
  );

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            if (!f3_legal(req_we, req_funct3)) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
              mis_q <= 1'b1;
              state <= RESP;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt)
            state <= we_q ? RESP : WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= ld_w;
            state   <= RESP;
          end else if (cnt == CW'(MAX_WAIT - 1)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign rsp_valid      = (state == RESP);
  assign rsp_rdata      = rsp_valid ? rdata_q : '0;
  assign rsp_misaligned = rsp_valid & mis_q;
  assign rsp_err        = rsp_valid & err_q;
  assign mem_req        = (state == REQ);
  assign mem_we         = mem_req & we_q;
  assign mem_be         = mem_req ? be_w : 4'b0000;
  assign mem_addr       = {addr_q[XLEN-1:2], 2'b00};

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter SHALL be: MAX_WAIT, default 16, the maximum number of cycles to wait for mem_rvalid before a timeout error.
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 areset_n  in  1  reset, synchronous and active-low.
REQ-004 req_valid  in  1  the core presents a load/store request.
REQ-005 req_ready  out  1  the LSU can accept a request; SHALL be high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  the RV32I funct3 size/sign code.
REQ-008 req_addr  in  XLEN  the byte address, taken from the ALU result.
REQ-009 req_wdata  in  XLEN  the store data (rs2).
REQ-010 rsp_valid  out  1  a one-cycle completion pulse.
REQ-011 rsp_rdata  out  XLEN  the aligned, extended load data; 0 for stores and errors.
REQ-012 rsp_misaligned  out  1  an address misalignment was detected; no memory access was made.
REQ-013 rsp_err  out  1  illegal funct3 or a timeout occurred.
REQ-014 busy  out  1  the FSM is not in IDLE.
REQ-015 mem_req  out  1  the memory request strobe.
REQ-016 mem_gnt  in  1  the memory accepts the request in this cycle.
REQ-017 mem_we  out  1  the memory write enable.
REQ-018 mem_addr  out  XLEN  the word address, req_addr with bits [1:0] forced to 0.
REQ-019 mem_be  out  4  the byte enables.
REQ-020 mem_wdata  out  32  the lane-replicated store data.
REQ-021 mem_rvalid  in  1  read data is valid.
REQ-022 mem_rdata  in  32  the read word.

Function
REQ-023 The FSM states SHALL be IDLE, REQ, WAIT and RESP.
REQ-024 In IDLE, req_valid and req_ready both high SHALL register we, funct3, addr and wdata.
  - Legal and aligned request: next state REQ.
  - Misaligned request or illegal funct3: next state RESP with the matching flag set.
REQ-025 Misalignment SHALL be defined as:
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] not equal to 0.
  - Byte accesses are never misaligned.
REQ-026 Legal funct3 values SHALL be:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - All others are illegal and set rsp_err.
REQ-027 In REQ, mem_req SHALL be 1 and mem_we/addr/be/wdata SHALL be held stable until mem_gnt.
  - Store with mem_gnt: next state RESP.
  - Load with mem_gnt: next state WAIT.
REQ-028 In WAIT, mem_rvalid SHALL capture the extracted data and move to RESP.
  - A wait counter increments each WAIT cycle.
  - When the counter reaches MAX_WAIT without mem_rvalid, the FSM SHALL move to RESP with rsp_err = 1.
REQ-029 In RESP, rsp_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-030 mem_rvalid SHALL be ignored in every state except WAIT, including in the same cycle as mem_gnt.
REQ-031 Store byte enables SHALL be:
  - SB: mem_be = 1 << addr[1:0].
  - SH: mem_be = 0011 for addr[1] = 0, 1100 for addr[1] = 1.
  - SW: mem_be = 1111.
REQ-032 Store data SHALL be wdata[7:0] replicated ×4 for SB, wdata[15:0] replicated ×2 for SH, and wdata unchanged for SW.
REQ-033 Load data SHALL be extracted from lane addr[1:0]:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: the full word.
  - mem_be SHALL be 1111 for all loads.
REQ-034 The minimum latency SHALL be: accept at cycle 0, mem_req at cycle 1.
  - Store: mem_gnt at cycle 1, rsp_valid at cycle 2.
  - Load: mem_rvalid at cycle 2, rsp_valid at cycle 3.
  - Error: rsp_valid at cycle 1.
REQ-035 Outside REQ, mem_req, mem_we and mem_be SHALL be 0.

Reset
REQ-036 When areset_n = 0 at a rising edge, the following SHALL hold next cycle, regardless of state:
  - state = IDLE and the wait counter = 0.
  - All captured registers = 0.
  - Outputs: rsp_valid = 0, rsp_rdata = 0, rsp_misaligned = 0, rsp_err = 0, mem_req = 0, busy = 0, req_ready = 1.
REQ-037 A reset during REQ or WAIT SHALL abandon the access, generate no response, and ignore any later mem_rvalid.

Structure
REQ-038 rv32i_pkg SHALL hold XLEN, the lsu_state_e enum, the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and LSU_MAX_WAIT_DEFAULT.
REQ-039 The combinational lane/extend logic SHALL be one sub-module, lsu_align, with mem_be, mem_wdata and load-data outputs.

Verification
REQ-040 Bench SHALL cover an SB store: addr 0x103, wdata 0xAABBCCDD, mem_gnt at cycle 1 -> mem_be 1000, mem_wdata 0xDDDDDDDD, mem_addr 0x100, rsp_valid at cycle 2.
REQ-041 Bench SHALL cover an LB load: addr 0x202, mem_rdata 0x12F45678 -> rsp_rdata 0xFFFFFFF4.
  - The same access with LBU -> rsp_rdata 0x000000F4.
REQ-042 Bench SHALL cover a misaligned LW: addr 0x006 -> no mem_req, rsp_valid at cycle 1 with rsp_misaligned = 1 and rsp_rdata = 0.
REQ-043 Bench SHALL cover a timeout: LW with mem_gnt, mem_rvalid never asserted, MAX_WAIT = 4 -> rsp_err = 1 after 4 WAIT cycles, FSM back in IDLE.
REQ-044 Bench SHALL cover mem_gnt held low for 5 cycles: mem_req and all mem_* outputs stay stable, then the access completes normally.
REQ-045 Bench SHALL cover a reset during WAIT, followed by mem_rvalid one cycle after reset release: no rsp_valid, req_ready = 1.
